// File: rtl/lsu_pkg.sv
// Shared LSU definitions: op codes, FSM encoding and lane geometry.
// Op bit 3 marks stores and bit 2 marks zero-extending loads.
package lsu_pkg;

  localparam int BYTE_W    = 8;
  localparam int NUM_LANES = 4;

  typedef enum logic [3:0] {
    LSU_LB  = 4'h0,
    LSU_LH  = 4'h1,
    LSU_LW  = 4'h2,
    LSU_LBU = 4'h4,
    LSU_LHU = 4'h5,
    LSU_SB  = 4'h8,
    LSU_SH  = 4'h9,
    LSU_SW  = 4'hA
  } lsu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_e;

  function automatic logic op_is_store(input logic [3:0] op);
    return op[3];
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Data-memory bus between the LSU (master) and memory (slave).
interface lsu_if #(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_wstrb;
  logic [XLEN-1:0]   mem_wdata;
  logic              mem_ack;
  logic [XLEN-1:0]   mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational store lane/strobe generation and load extraction/extension.
// bad flags misaligned halves/words and any op code outside the legal set.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [3:0]      op,
  input  logic [1:0]      off,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rword,
  output logic            bad,
  output logic            we,
  output logic [3:0]      wstrb,
  output logic [XLEN-1:0] wlane,
  output logic [XLEN-1:0] rext
);

  logic [NUM_LANES-1:0][BYTE_W-1:0] wl;
  logic [NUM_LANES-1:0][BYTE_W-1:0] rl;
  logic [BYTE_W-1:0]                rbyte;
  logic [2*BYTE_W-1:0]              rhalf;

  assign rl    = rword;
  assign rbyte = rl[off];
  assign rhalf = off[1] ? rword[31:16] : rword[15:0];

  // Sub-word stores replicate the source so every lane carries it; strobes pick the lane.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign wl[i] = (op == LSU_SB) ? wdata[BYTE_W-1:0] :
                   (op == LSU_SH) ? wdata[BYTE_W*(i%2) +: BYTE_W] :
                                    wdata[BYTE_W*i +: BYTE_W];
  end
  assign wlane = wl;

  always_comb begin
    bad   = 1'b0;
    we    = op_is_store(op);
    wstrb = 4'b0000;
    rext  = '0;
    case (op)
      LSU_LB:  rext = {{(XLEN-BYTE_W){rbyte[BYTE_W-1]}}, rbyte};
      LSU_LBU: rext = {{(XLEN-BYTE_W){1'b0}}, rbyte};
      LSU_LH: begin
        rext = {{(XLEN-2*BYTE_W){rhalf[2*BYTE_W-1]}}, rhalf};
        bad  = off[0];
      end
      LSU_LHU: begin
        rext = {{(XLEN-2*BYTE_W){1'b0}}, rhalf};
        bad  = off[0];
      end
      LSU_LW: begin
        rext = rword;
        bad  = |off;
      end
      LSU_SB:  wstrb = 4'b0001 << off;
      LSU_SH: begin
        wstrb = off[1] ? 4'b1100 : 4'b0011;
        bad   = off[0];
      end
      LSU_SW: begin
        wstrb = 4'b1111;
        bad   = |off;
      end
      default: begin
        bad = 1'b1;
        we  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/lsu.sv
// RV32I load/store unit: one data-memory transaction per request over req/ack,
// stalling the core until done; misaligned or illegal ops finish without memory access.
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [3:0]        req_op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [XLEN-1:0]   wdata,
  output logic              stall,
  output logic              done,
  output logic [XLEN-1:0]   rdata,
  output logic              misalign,
  lsu_if.master             mem
);

  lsu_state_e      state, nxt;
  logic [3:0]      op_q;
  logic [1:0]      off_q;
  logic            mis_q;

  logic [3:0]      a_op;
  logic [1:0]      a_off;
  logic            a_bad;
  logic            a_we;
  logic [3:0]      a_wstrb;
  logic [XLEN-1:0] a_wlane;
  logic [XLEN-1:0] a_rext;
  logic            accept;

  // In IDLE the aligner decodes the incoming request; afterwards it serves the latched op.
  assign a_op   = (state == ST_IDLE) ? req_op    : op_q;
  assign a_off  = (state == ST_IDLE) ? addr[1:0] : off_q;
  assign accept = (state == ST_IDLE) && req_valid;

  lsu_align #(.XLEN(XLEN)) u_align (
    .op    (a_op),
    .off   (a_off),
    .wdata (wdata),
    .rword (mem.mem_rdata),
    .bad   (a_bad),
    .we    (a_we),
    .wstrb (a_wstrb),
    .wlane (a_wlane),
    .rext  (a_rext)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt         = state;
    stall       = 1'b0;
    done        = 1'b0;
    misalign    = 1'b0;
    mem.mem_req = 1'b0;
    case (state)
      ST_IDLE: begin
        stall = req_valid;
        if (req_valid) nxt = a_bad ? ST_RESP : ST_ACCESS;
      end
      ST_ACCESS: begin
        stall       = 1'b1;
        mem.mem_req = 1'b1;
        if (mem.mem_ack) nxt = ST_RESP;
      end
      ST_RESP: begin
        done     = 1'b1;
        misalign = mis_q;
        nxt      = ST_IDLE;
      end
      default: nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q          <= 4'h0;
      off_q         <= 2'b00;
      mis_q         <= 1'b0;
      rdata         <= '0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wstrb <= 4'b0000;
      mem.mem_wdata <= '0;
    end else begin
      if (accept) begin
        op_q  <= req_op;
        off_q <= addr[1:0];
        mis_q <= a_bad;
        // Bus fields only move for a real access so they stay stable across ACCESS.
        if (!a_bad) begin
          mem.mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
          mem.mem_we    <= a_we;
          mem.mem_wstrb <= a_we ? a_wstrb : 4'b0000;
          mem.mem_wdata <= a_wlane;
        end
      end
      if (state == ST_ACCESS && mem.mem_ack) begin
        mem.mem_we    <= 1'b0;
        mem.mem_wstrb <= 4'b0000;
        if (!op_is_store(op_q)) rdata <= a_rext;
      end
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: stimulus pushes expected done responses to a queue,
// a negedge monitor pops and compares whenever done pulses.
module tb_lsu;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [3:0]  req_op = 4'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        stall, done, misalign;
  logic [31:0] rdata;

  lsu_if #(.ADDR_W(32), .XLEN(32)) mif ();

  lsu #(.ADDR_W(32), .XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_op    (req_op),
    .addr      (addr),
    .wdata     (wdata),
    .stall     (stall),
    .done      (done),
    .rdata     (rdata),
    .misalign  (misalign),
    .mem       (mif.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic        mis;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 expected=0 at %0t", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rdata", rdata, e.rd);
        chk("misalign", 32'(misalign), 32'(e.mis));
      end
    end
  end

  // One request; delay = extra ack wait cycles in ACCESS.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                        input int delay, input logic [31:0] mrd, input logic [31:0] exp_rd,
                        input logic exp_mis, input logic exp_we, input logic [3:0] exp_strb,
                        input logic [31:0] exp_wd);
    @(posedge clk) #1;
    req_valid = 1'b1;
    req_op    = op;
    addr      = a;
    wdata     = wd;
    @(negedge clk);
    chk("stall_req", 32'(stall), 32'd1);
    chk("mem_req_idle", 32'(mif.mem_req), 32'd0);
    sb.push_back('{rd: exp_rd, mis: exp_mis});
    @(posedge clk) #1;
    req_valid = 1'b0;
    wdata     = 32'h0;
    if (!exp_mis) begin
      for (int i = 0; i <= delay; i++) begin
        @(negedge clk);
        chk("mem_req", 32'(mif.mem_req), 32'd1);
        chk("stall_acc", 32'(stall), 32'd1);
        chk("done_early", 32'(done), 32'd0);
        chk("mem_addr", mif.mem_addr, {a[31:2], 2'b00});
        chk("mem_we", 32'(mif.mem_we), 32'(exp_we));
        chk("mem_wstrb", 32'(mif.mem_wstrb), 32'(exp_strb));
        if (exp_we) chk("mem_wdata", mif.mem_wdata, exp_wd);
        if (i == delay) begin
          mif.mem_ack   = 1'b1;
          mif.mem_rdata = mrd;
        end
      end
      @(posedge clk) #1;
      mif.mem_ack   = 1'b0;
      mif.mem_rdata = 32'h5A5A5A5A;
    end
    @(negedge clk);
    chk("done_latency", 32'(done), 32'd1);
    chk("stall_done", 32'(stall), 32'd0);
    chk("mem_req_done", 32'(mif.mem_req), 32'd0);
  endtask

  initial begin
    mif.mem_ack   = 1'b0;
    mif.mem_rdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_misalign", 32'(misalign), 32'd0);
    chk("rst_mem_req", 32'(mif.mem_req), 32'd0);
    chk("rst_mem_we", 32'(mif.mem_we), 32'd0);
    chk("rst_wstrb", 32'(mif.mem_wstrb), 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_mem_addr", mif.mem_addr, 32'h0);
    chk("rst_mem_wdata", mif.mem_wdata, 32'h0);
    @(posedge clk) #1;
    rst = 1'b0;

    //     op       addr          wdata         dly mrd           exp_rd        mis  we   strb     exp_wd
    run_op(LSU_LW,  32'h100, 32'h0,        0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 4'b0000, 32'h0);
    run_op(LSU_LB,  32'h103, 32'h0,        0, 32'h80112233, 32'hFFFFFF80, 1'b0, 1'b0, 4'b0000, 32'h0);
    run_op(LSU_LBU, 32'h103, 32'h0,        0, 32'h80112233, 32'h00000080, 1'b0, 1'b0, 4'b0000, 32'h0);
    run_op(LSU_LHU, 32'h102, 32'h0,        1, 32'h80112233, 32'h00008011, 1'b0, 1'b0, 4'b0000, 32'h0);
    run_op(LSU_LH,  32'h102, 32'h0,        0, 32'h80112233, 32'hFFFF8011, 1'b0, 1'b0, 4'b0000, 32'h0);
    run_op(LSU_LB,  32'h101, 32'h0,        0, 32'h80112233, 32'h00000022, 1'b0, 1'b0, 4'b0000, 32'h0);
    run_op(LSU_LH,  32'h100, 32'h0,        0, 32'h80117FFF, 32'h00007FFF, 1'b0, 1'b0, 4'b0000, 32'h0);
    run_op(LSU_SH,  32'h206, 32'h1234ABCD, 0, 32'hFFFFFFFF, 32'h00007FFF, 1'b0, 1'b1, 4'b1100, 32'hABCDABCD);
    run_op(LSU_SH,  32'h204, 32'h1234ABCD, 0, 32'hFFFFFFFF, 32'h00007FFF, 1'b0, 1'b1, 4'b0011, 32'hABCDABCD);
    run_op(LSU_SB,  32'h301, 32'h000000A5, 0, 32'hFFFFFFFF, 32'h00007FFF, 1'b0, 1'b1, 4'b0010, 32'hA5A5A5A5);
    run_op(LSU_LW,  32'h101, 32'h0,        0, 32'h0,        32'h00007FFF, 1'b1, 1'b0, 4'b0000, 32'h0);
    run_op(LSU_SH,  32'h203, 32'h1111,     0, 32'h0,        32'h00007FFF, 1'b1, 1'b0, 4'b0000, 32'h0);
    run_op(LSU_SW,  32'h402, 32'h1111,     0, 32'h0,        32'h00007FFF, 1'b1, 1'b0, 4'b0000, 32'h0);
    run_op(4'hF,    32'h400, 32'h0,        0, 32'h0,        32'h00007FFF, 1'b1, 1'b0, 4'b0000, 32'h0);
    run_op(LSU_SW,  32'h400, 32'hCAFEF00D, 5, 32'hFFFFFFFF, 32'h00007FFF, 1'b0, 1'b1, 4'b1111, 32'hCAFEF00D);

    // Stray ack while idle must not complete anything.
    @(posedge clk) #1;
    mif.mem_ack   = 1'b1;
    mif.mem_rdata = 32'hFFFFFFFF;
    repeat (2) begin
      @(negedge clk);
      chk("stray_ack_done", 32'(done), 32'd0);
      chk("stray_ack_req", 32'(mif.mem_req), 32'd0);
    end
    @(posedge clk) #1;
    mif.mem_ack = 1'b0;
    @(negedge clk);
    chk("stray_ack_rdata", rdata, 32'h00007FFF);

    // Reset while waiting for ack abandons the access.
    @(posedge clk) #1;
    req_valid = 1'b1;
    req_op    = LSU_LW;
    addr      = 32'h80;
    @(posedge clk) #1;
    req_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("abandon_req_hi", 32'(mif.mem_req), 32'd1);
    end
    @(posedge clk) #1;
    rst = 1'b1;
    @(posedge clk) #1;
    @(negedge clk);
    chk("abandon_req_lo", 32'(mif.mem_req), 32'd0);
    chk("abandon_done", 32'(done), 32'd0);
    chk("abandon_stall", 32'(stall), 32'd0);
    @(posedge clk) #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abandon_done2", 32'(done), 32'd0);
    chk("abandon_rdata", rdata, 32'h0);

    run_op(LSU_LW,  32'h010, 32'h0,        2, 32'h12345678, 32'h12345678, 1'b0, 1'b0, 4'b0000, 32'h0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
